// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package divider_pkg;
  localparam int WIDTH_DEF = 8;
  // Wide enough to slice down to any supported WIDTH.
  localparam logic [63:0] DIV_ZERO_QUOT = '1;

  typedef enum logic [2:0] {IDLE, START, SHIFT, SUB, HOLD} state_t;
endpackage

// File: rtl/divider_datapath.sv
// Partial remainder (A), dividend/quotient (Q) and divisor (B) registers
// with the shift and trial-subtract steps of a restoring division.
module divider_datapath
  import divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic             shift,
  input  logic             sub_step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic             b_zero,
  output logic             diff_neg,
  output logic [WIDTH-1:0] quot_next,
  output logic [WIDTH-1:0] rem_next
);

  // A carries one extra bit so the trial-subtract sign is exact for any B.
  logic [WIDTH:0]   a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   diff;

  assign diff      = a - {1'b0, b};
  assign diff_neg  = diff[WIDTH];
  assign b_zero    = (b == '0);
  assign quot_next = {q[WIDTH-1:1], ~diff_neg};
  assign rem_next  = diff_neg ? a[WIDTH-1:0] : diff[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= '0;
      q <= '0;
      b <= '0;
    end else if (ld) begin
      a <= '0;
      q <= dividend;
      b <= divisor;
    end else if (shift) begin
      {a, q} <= {a[WIDTH-1:0], q, 1'b0};
    end else if (sub_step && !diff_neg) begin
      a    <= diff;
      q[0] <= 1'b1;
    end
  end

endmodule

// File: rtl/divider_unit.sv
// Execute-driven control FSM and step counter for the restoring divider;
// one division per Execute press, result held until Execute is released.
module divider_unit
  import divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Execute,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  // state | meaning
  // IDLE  | waiting for Execute; last result still visible
  // START | divisor-zero check, counter preset
  // SHIFT | shift {A,Q} left one bit
  // SUB   | trial subtract, set quotient bit, count step
  // HOLD  | result valid, wait for Execute release

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          state;
  logic [CW-1:0]   count;
  logic            ld, shift, sub_step;
  logic [WIDTH-1:0] q, quot_next, rem_next;
  logic            b_zero, diff_neg;

  assign ld       = (state == IDLE) && Execute;
  assign shift    = (state == SHIFT);
  assign sub_step = (state == SUB);

  divider_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk      (Clk),
    .rst_n    (Reset),
    .ld       (ld),
    .shift    (shift),
    .sub_step (sub_step),
    .dividend (Dividend),
    .divisor  (Divisor),
    .q        (q),
    .b_zero   (b_zero),
    .diff_neg (diff_neg),
    .quot_next(quot_next),
    .rem_next (rem_next)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      count     <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivZero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Busy <= 1'b0;
          Done <= 1'b0;
          if (Execute) begin
            DivZero <= 1'b0;
            Busy    <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (b_zero) begin
            DivZero   <= 1'b1;
            Quotient  <= DIV_ZERO_QUOT[WIDTH-1:0];
            Remainder <= q;
            Busy      <= 1'b0;
            Done      <= 1'b1;
            state     <= HOLD;
          end else begin
            count <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: state <= SUB;
        SUB: begin
          // Result taken from the datapath's next values so the final bit lands here.
          if (count == LAST) begin
            Quotient  <= quot_next;
            Remainder <= rem_next;
            Busy      <= 1'b0;
            Done      <= 1'b1;
            state     <= HOLD;
          end else begin
            count <= count + 1'b1;
            state <= SHIFT;
          end
        end
        HOLD: begin
          if (!Execute) begin
            Done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          Busy    <= 1'b0;
          Done    <= 1'b0;
          DivZero <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_unit.sv
// Self-checking bench for divider_unit: directed vectors, random operands
// against an arithmetic reference, and multi-cycle corner sequences.
module tb_divider_unit;
  localparam int W = 8;
  localparam int NORMAL_LAT = 2 * W + 2;
  localparam int ZERO_LAT = 2;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         Execute = 1'b0;
  logic [W-1:0] Dividend = '0;
  logic [W-1:0] Divisor = '0;
  logic [W-1:0] Quotient, Remainder;
  logic         Busy, Done, DivZero;

  int pass_cnt = 0;
  int total_cnt = 0;

  divider_unit #(.WIDTH(W)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Execute  (Execute),
    .Dividend (Dividend),
    .Divisor  (Divisor),
    .Quotient (Quotient),
    .Remainder(Remainder),
    .Busy     (Busy),
    .Done     (Done),
    .DivZero  (DivZero)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int dvd;
    int dvs;
    int q;
    int r;
    int dz;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model straight from the arithmetic definition.
  task automatic model(input int dvd, input int dvs, output int q, output int r,
                       output int dz, output int lat);
    if (dvs == 0) begin
      q = 255; r = dvd; dz = 1; lat = ZERO_LAT;
    end else begin
      q = dvd / dvs; r = dvd % dvs; dz = 0; lat = NORMAL_LAT;
    end
  endtask

  task automatic do_op(input string tag, input int dvd, input int dvs,
                       input int eq, input int er, input int edz, input int elat);
    int  edge_n;
    bit  seen;
    bit  busy_ok;
    logic [31:0] v;
    edge_n = 0; seen = 0; busy_ok = 1;
    v = dvd; @(negedge Clk); Dividend = v[W-1:0];
    v = dvs; Divisor = v[W-1:0];
    Execute = 1'b1;
    while (!seen && edge_n < 40) begin
      @(posedge Clk); #1;
      edge_n++;
      if (Done) seen = 1;
      else if (!Busy) busy_ok = 0;
    end
    chk({tag, " latency"}, edge_n, elat);
    chk({tag, " busy_during"}, int'(busy_ok), 1);
    chk({tag, " busy_at_done"}, int'(Busy), 0);
    chk({tag, " quotient"}, int'(Quotient), eq);
    chk({tag, " remainder"}, int'(Remainder), er);
    chk({tag, " divzero"}, int'(DivZero), edz);
    @(negedge Clk); Execute = 1'b0;
    @(posedge Clk); #1;
    chk({tag, " done_after_release"}, int'(Done), 0);
    chk({tag, " quotient_persist"}, int'(Quotient), eq);
  endtask

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int q, r, dz, lat, dvd, dvs, edge_n, done_cnt, first_done;

    vecs[0] = '{100, 7, 14, 2, 0};
    vecs[1] = '{255, 1, 255, 0, 0};
    vecs[2] = '{5, 9, 0, 5, 0};
    vecs[3] = '{255, 255, 1, 0, 0};
    vecs[4] = '{200, 0, 255, 200, 1};
    vecs[5] = '{10, 3, 3, 1, 0};

    #2;
    chk("rst quotient", int'(Quotient), 0);
    chk("rst remainder", int'(Remainder), 0);
    chk("rst busy", int'(Busy), 0);
    chk("rst done", int'(Done), 0);
    chk("rst divzero", int'(DivZero), 0);
    @(negedge Clk); Reset = 1'b1;
    @(negedge Clk);

    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r,
            vecs[i].dz, (vecs[i].dvs == 0) ? ZERO_LAT : NORMAL_LAT);

    for (int i = 0; i < 24; i++) begin
      dvd = $urandom_range(0, 255);
      dvs = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      model(dvd, dvs, q, r, dz, lat);
      do_op($sformatf("rnd%0d_%0d_%0d", i, dvd, dvs), dvd, dvs, q, r, dz, lat);
    end

    // Reset at edge 9 of a 100/7 operation.
    @(negedge Clk); Dividend = 8'd100; Divisor = 8'd7; Execute = 1'b1;
    repeat (9) @(posedge Clk);
    #1 Reset = 1'b0;
    #1;
    chk("midrst quotient", int'(Quotient), 0);
    chk("midrst remainder", int'(Remainder), 0);
    chk("midrst busy", int'(Busy), 0);
    chk("midrst done", int'(Done), 0);
    chk("midrst divzero", int'(DivZero), 0);
    @(negedge Clk); Execute = 1'b0; Reset = 1'b1;
    @(posedge Clk); #1;
    chk("midrst idle_busy", int'(Busy), 0);
    do_op("post_rst", 100, 7, 14, 2, 0, NORMAL_LAT);

    // Execute held for 40 edges: single operation, Done stays high.
    @(negedge Clk); Dividend = 8'd45; Divisor = 8'd6; Execute = 1'b1;
    done_cnt = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge Clk); #1;
      if (Done) done_cnt++;
    end
    chk("held done_edges", done_cnt, 40 - NORMAL_LAT + 1);
    chk("held busy_end", int'(Busy), 0);
    chk("held quotient", int'(Quotient), 7);
    chk("held remainder", int'(Remainder), 3);
    @(negedge Clk); Execute = 1'b0;
    @(posedge Clk); #1;
    chk("held release_done", int'(Done), 0);
    do_op("rerun_77_5", 77, 5, 15, 2, 0, NORMAL_LAT);

    // Operands changed at edge 3, Execute dropped at edge 5.
    @(negedge Clk); Dividend = 8'd100; Divisor = 8'd7; Execute = 1'b1;
    first_done = 0;
    for (edge_n = 1; edge_n <= 30 && first_done == 0; edge_n++) begin
      @(posedge Clk); #1;
      if (edge_n == 3) begin Dividend = 8'd3; Divisor = 8'd0; end
      if (edge_n == 5) Execute = 1'b0;
      if (Done) first_done = edge_n;
    end
    chk("chg done_edge", first_done, NORMAL_LAT);
    chk("chg quotient", int'(Quotient), 14);
    chk("chg remainder", int'(Remainder), 2);
    chk("chg divzero", int'(DivZero), 0);
    @(posedge Clk); #1;
    chk("chg idle_done", int'(Done), 0);
    chk("chg idle_busy", int'(Busy), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/divider_unit.md
Name: divider_unit

Overview:
- Sequential 8-bit unsigned restoring divider (shift/subtract), the inverse-operation companion to the add/shift multiplier control.
- Contains the Execute-driven control FSM and the remainder/quotient datapath.
- Sits between switch/operand registers and the hex display logic on the lab top level.
- Same Execute protocol as the multiplier: one operation per Execute press; Execute must be released before the next operation starts.

Parameters:
- WIDTH, 8, operand, quotient and remainder width in bits.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Execute  in  1  start request, level-sensitive and synchronous; held high by the user for the duration of an operation.
- Dividend  in  WIDTH  numerator; sampled only on the capture edge.
- Divisor  in  WIDTH  denominator; sampled only on the capture edge.
- Quotient  out  WIDTH  result quotient.
- Remainder  out  WIDTH  result remainder.
- Busy  out  1  high while a division is in progress.
- Done  out  1  high while the result is held.
- DivZero  out  1  divide-by-zero flag for the last operation.

Behaviour:
- Reset low (async): state=IDLE; A, Q, B and count cleared; Quotient=0, Remainder=0, Busy=0, Done=0, DivZero=0. Reset mid-operation aborts immediately with no partial result retained.
- Internal registers:
  - A: WIDTH+1 bits, partial remainder.
  - Q: WIDTH bits, dividend/quotient shift register.
  - B: WIDTH bits, divisor.
  - count: clog2(WIDTH) bits.
- IDLE: Busy=0, Done=0. If Execute=1 on a rising edge (the capture edge), then B<=Divisor, Q<=Dividend, A<=0, DivZero<=0, and go to START.
- START: Busy=1.
  - If B==0: DivZero<=1, Quotient<=all ones, Remainder<=Dividend as captured (Q), go to HOLD.
  - Otherwise: count<=0, go to SHIFT.
- SHIFT: Busy=1. Shift {A,Q} left by 1 and shift 0 into Q[0]. Go to SUB.
- SUB: Busy=1.
  - Compute diff = A - {0,B}, WIDTH+1 bits.
  - If diff is non-negative (MSB=0): A<=diff and Q[0]<=1. Otherwise A is unchanged and Q[0] stays 0.
  - If count==WIDTH-1: Quotient<=Q result, Remainder<=A result (low WIDTH bits), go to HOLD.
  - Otherwise: count<=count+1, go to SHIFT.
- HOLD: Busy=0, Done=1. Stay while Execute=1. Go to IDLE when Execute=0.
- Quotient, Remainder and DivZero persist through IDLE until the next capture edge (DivZero clears on capture).
- Latency, counting the capture edge as edge 1:
  - Normal operation: Done rises at edge 2*WIDTH+2 (18 for WIDTH=8).
  - Divisor 0: Done rises at edge 2.
- Execute dropped mid-operation: ignored; the division completes; HOLD then exits to IDLE on the next edge.
- Execute held high after HOLD: no restart. A new operation requires IDLE with Execute re-asserted.
- Operand inputs changing after the capture edge have no effect.
- Width rule: A is one bit wider than B so the trial subtraction sign is exact for B up to 2^WIDTH-1. The invariant A<B holds after every SUB.
- The FSM default branch returns to IDLE with all outputs at their inactive values.

Decomposition:
- Package divider_pkg:
  - state enum {IDLE, START, SHIFT, SUB, HOLD}
  - default WIDTH constant
  - divide-by-zero quotient constant (all ones)
- Sub-module divider_datapath: A/Q/B registers, shifter and subtractor. Controlled by ld, shift and sub_step strobes; returns the diff sign.
- divider_unit: FSM and count.

Test Plan:
- Dividend=100, Divisor=7, Execute held -> Done at edge 18; Quotient=14, Remainder=2, DivZero=0; Busy high for edges 1-17.
- 255/1 -> Quotient=255, Remainder=0. 5/9 -> Quotient=0, Remainder=5. 255/255 -> Quotient=1, Remainder=0.
- 200/0 -> Done at edge 2, DivZero=1, Quotient=8'hFF, Remainder=200; a following 10/3 -> DivZero=0, Quotient=3, Remainder=1.
- Reset pulsed low at edge 9 of a 100/7 operation -> all outputs 0 immediately, state IDLE; a new operation after reset release gives the correct result.
- Execute held high for 40 cycles -> exactly one operation and Done stays high. Execute low -> IDLE next edge. Re-raise with 77/5 -> Quotient=15, Remainder=2.
- Operands changed on edge 3 of an operation -> result reflects only the captured operands. Execute dropped at edge 5 -> operation still completes at edge 18.
